dbchecker_rx_burst_splitter: RTL and testbench
==============================================

Name: dbchecker_rx_burst_splitter

Overview:
- Sits directly upstream of the DBChecker RX slave read port, between the NIC/DMA read master and the checker.
- Splits each incoming AXI4 INCR read burst into sub-bursts that never cross a 4 KiB boundary and never exceed MAX_BEATS beats, so the checker validates every sub-burst against a single bound entry.
- On the R path it regenerates rlast so the upstream master sees exactly one rlast per original burst.

Parameters:
- ADDR_WIDTH, 64, AR address width on both sides.
- DATA_WIDTH, 128, R data width.
- MAX_BEATS, 16, maximum beats per emitted sub-burst; power of two, 1..256.
- TAG_DEPTH, 4, depth of the sub-burst "final" flag FIFO; power of two, at least 2.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- s_ar_valid / s_ar_ready  in/out  1/1  upstream AR handshake.
- s_ar_addr  in  ADDR_WIDTH  burst start address.
- s_ar_len  in  8  beats-1.
- s_ar_size  in  3  log2 bytes per beat; at most log2(DATA_WIDTH/8).
- s_ar_burst  in  2  burst type.
- s_ar_prot, s_ar_cache, s_ar_qos  in  3/4/4  sideband, copied to every sub-burst.
- m_ar_valid / m_ar_ready  out/in  1/1  downstream AR handshake to DBChecker.
- m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_prot, m_ar_cache, m_ar_qos  out  ADDR_WIDTH/8/3/2/3/4/4  sub-burst request.
- m_r_valid / m_r_ready  in/out  1/1  R from DBChecker.
- m_r_data, m_r_resp, m_r_last  in  DATA_WIDTH/2/1.
- s_r_valid / s_r_ready  out/in  1/1  R to upstream master.
- s_r_data, s_r_resp, s_r_last  out  DATA_WIDTH/2/1.

Behaviour:
Reset (reset=0):
- FSM goes to IDLE; tag FIFO is emptied.
- s_ar_ready=0 and m_ar_valid=0 while reset is held; all m_ar_* payload registers are 0.
- A reset mid-burst abandons the request with no further AR issued. R beats still in flight are the system's responsibility.

AR FSM, state IDLE:
- s_ar_ready=1.
- On s_ar handshake, latch addr, remaining=len+1, size, burst and sideband, then go to SPLIT.

AR FSM, state SPLIT:
- bytes = 1<<size.
- aligned = addr & ~(bytes-1).
- to_bound = (4096 - aligned[11:0]) >> size.
- beats = min(remaining, MAX_BEATS, to_bound), computed in 13-bit arithmetic.
- If burst is not INCR (FIXED or WRAP), beats=remaining: the request passes through whole, unmodified.
- Payload is registered: m_ar_addr=addr, m_ar_len=beats-1, other fields as latched.
- m_ar_valid=1 only when the tag FIFO is not full. Once asserted, valid and payload stay stable until m_ar_ready.
- On m_ar handshake:
  - push final=(beats==remaining) into the tag FIFO.
  - For INCR, addr <= aligned + (beats<<size); otherwise addr is unchanged.
  - remaining -= beats.
  - If remaining reaches 0, go to IDLE; otherwise a new sub-burst is presented the next cycle.
- Only the first sub-burst of a burst can start at an unaligned address. Later sub-bursts start at the beat-aligned address.
- Zero-cycle bubble requirement: the IDLE→SPLIT first m_ar_valid appears 1 cycle after s_ar handshake. Back-to-back sub-bursts may issue on consecutive cycles.

R path (combinational pass-through):
- s_r_valid=m_r_valid, m_r_ready=s_r_ready, s_r_data=m_r_data, s_r_resp=m_r_resp.
- s_r_last = m_r_last & fifo_head.final.
- On an m_r handshake with m_r_last=1, pop the FIFO.
- Popping an empty FIFO is a protocol violation by downstream; the pop is ignored.
- Simultaneous push and pop in one cycle is supported, including when the FIFO is full: the pop frees the slot and the push succeeds.

Full/empty:
- FIFO full stalls only m_ar_valid.
- FIFO empty has no effect on R forwarding.

Width rules:
- Address increment wraps modulo 2^ADDR_WIDTH.
- len arithmetic is 9-bit, so len=255 gives remaining=256.

Test Plan:
- INCR addr=0x0FF0, len=7, size=4 (8 beats × 16 B) -> sub-bursts (0x0FF0, len 0) and (0x1000, len 6); upstream sees a single rlast on beat 8.
- INCR addr=0x2000, len=63, size=4, MAX_BEATS=16 -> four ARs at 0x2000/0x2100/0x2200/0x2300, each len 15. Only the 4th R burst's last beat drives s_r_last=1.
- WRAP addr=0x0FF0, len=3, size=4 -> one AR forwarded unchanged (addr 0x0FF0, len 3, burst WRAP); s_r_last follows m_r_last.
- Hold m_r_valid=0 and issue 0x2000/len 255/size 4 with TAG_DEPTH=4 -> exactly 4 ARs issue, then m_ar_valid stays 0. Completing one R sub-burst (16 beats with last) releases the 5th AR the next cycle.
- Unaligned INCR addr=0x0FF8, len=1, size=4 -> first AR addr 0x0FF8, len 0; second AR addr 0x1000, len 0.
- Assert reset in SPLIT after 1 of 4 sub-bursts -> m_ar_valid=0 and s_ar_ready=0 immediately. After release, s_ar_ready=1 with the FIFO empty, and a new request splits correctly.

Source files
------------

// File: rtl/dbchecker_rx_burst_splitter.sv
// AXI4 read burst splitter placed in front of the DBChecker RX slave port.
// INCR bursts are cut at 4 KiB and MAX_BEATS; rlast is rebuilt for the original burst.
module dbchecker_rx_burst_splitter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BEATS  = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  // upstream AR
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [7:0]            s_ar_len,
  input  logic [2:0]            s_ar_size,
  input  logic [1:0]            s_ar_burst,
  input  logic [2:0]            s_ar_prot,
  input  logic [3:0]            s_ar_cache,
  input  logic [3:0]            s_ar_qos,
  // downstream AR
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ADDR_WIDTH-1:0] m_ar_addr,
  output logic [7:0]            m_ar_len,
  output logic [2:0]            m_ar_size,
  output logic [1:0]            m_ar_burst,
  output logic [2:0]            m_ar_prot,
  output logic [3:0]            m_ar_cache,
  output logic [3:0]            m_ar_qos,
  // downstream R
  input  logic                  m_r_valid,
  output logic                  m_r_ready,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  input  logic [1:0]            m_r_resp,
  input  logic                  m_r_last,
  // upstream R
  output logic                  s_r_valid,
  input  logic                  s_r_ready,
  output logic [DATA_WIDTH-1:0] s_r_data,
  output logic [1:0]            s_r_resp,
  output logic                  s_r_last
);

  localparam logic [1:0]            BURST_INCR  = 2'b01;
  localparam int                    PTR_W       = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0]        DEPTH_C     = (PTR_W+1)'(TAG_DEPTH);
  localparam logic [PTR_W:0]        CNT_ONE     = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE     = PTR_W'(1);
  localparam logic [12:0]           MAX_BEATS_C = 13'(MAX_BEATS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Beats for one sub-burst: INCR is capped by remaining, MAX_BEATS and the 4 KiB page.
  function automatic logic [8:0] split_beats(input logic [11:0] addr_lo,
                                             input logic [2:0]  size,
                                             input logic [8:0]  rem,
                                             input logic [1:0]  burst);
    logic [12:0] mask;
    logic [12:0] aligned;
    logic [12:0] to_bound;
    logic [12:0] lim;
    mask     = (13'd1 << size) - 13'd1;
    aligned  = {1'b0, addr_lo} & ~mask;
    to_bound = (13'd4096 - aligned) >> size;
    lim      = {4'd0, rem};
    if (burst == BURST_INCR) begin
      if (MAX_BEATS_C < lim) begin
        lim = MAX_BEATS_C;
      end else begin
        lim = lim;
      end
      if (to_bound < lim) begin
        lim = to_bound;
      end else begin
        lim = lim;
      end
    end else begin
      lim = {4'd0, rem};
    end
    return lim[8:0];
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    s_ar_ready_r;
  logic                    m_ar_valid_r;
  logic                    valid_next_s;
  logic [ADDR_WIDTH-1:0]   m_ar_addr_r;
  logic [7:0]              m_ar_len_r;
  logic [2:0]              m_ar_size_r;
  logic [1:0]              m_ar_burst_r;
  logic [2:0]              m_ar_prot_r;
  logic [3:0]              m_ar_cache_r;
  logic [3:0]              m_ar_qos_r;
  logic [8:0]              cur_beats_r;
  logic [8:0]              remaining_r;

  logic                    ar_hs_s;
  logic                    m_hs_s;
  logic                    load_s;
  logic [ADDR_WIDTH-1:0]   src_addr_s;
  logic [8:0]              src_rem_s;
  logic [2:0]              src_size_s;
  logic [1:0]              src_burst_s;
  logic [8:0]              beats_s;
  logic [8:0]              len_s;
  logic [8:0]              rem_adv_s;
  logic [ADDR_WIDTH-1:0]   size_mask_s;
  logic [ADDR_WIDTH-1:0]   step_s;
  logic [ADDR_WIDTH-1:0]   addr_adv_s;
  logic                    final_s;

  logic                    tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [PTR_W:0]          count_r;
  logic [PTR_W:0]          count_next_s;
  logic                    fifo_empty_s;
  logic                    full_next_s;
  logic                    push_s;
  logic                    pop_s;

  assign ar_hs_s = s_ar_valid && s_ar_ready_r;
  assign m_hs_s  = m_ar_valid_r && m_ar_ready;

  // Where the following sub-burst starts; later sub-bursts are beat aligned.
  assign size_mask_s = (ADDR_ONE << m_ar_size_r) - ADDR_ONE;
  assign step_s      = {{(ADDR_WIDTH-9){1'b0}}, cur_beats_r} << m_ar_size_r;
  assign addr_adv_s  = (m_ar_burst_r == BURST_INCR) ? ((m_ar_addr_r & ~size_mask_s) + step_s)
                                                    : m_ar_addr_r;
  assign rem_adv_s   = remaining_r - cur_beats_r;
  assign final_s     = (cur_beats_r == remaining_r);

  assign beats_s = split_beats(src_addr_s[11:0], src_size_s, src_rem_s, src_burst_s);
  assign len_s   = beats_s - 9'd1;

  // FSM next state and selection of the source for the next sub-burst payload.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    src_addr_s   = addr_adv_s;
    src_rem_s    = rem_adv_s;
    src_size_s   = m_ar_size_r;
    src_burst_s  = m_ar_burst_r;
    case (state_r)
      ST_IDLE: begin
        if (ar_hs_s) begin
          state_next_s = ST_SPLIT;
          load_s       = 1'b1;
          src_addr_s   = s_ar_addr;
          src_rem_s    = {1'b0, s_ar_len} + 9'd1;
          src_size_s   = s_ar_size;
          src_burst_s  = s_ar_burst;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SPLIT: begin
        if (m_hs_s) begin
          if (rem_adv_s == 9'd0) begin
            state_next_s = ST_IDLE;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          state_next_s = ST_SPLIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Tag FIFO occupancy; a pop while full lets the same-cycle push land.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  assign fifo_empty_s = (count_r == '0);
  assign full_next_s  = (count_next_s == DEPTH_C);
  assign pop_s        = m_r_valid && s_r_ready && m_r_last && !fifo_empty_s;
  assign push_s       = m_hs_s && ((count_r != DEPTH_C) || pop_s);

  // AR valid: held once raised, otherwise raised whenever a tag slot is free.
  always_comb begin
    valid_next_s = 1'b0;
    if (state_next_s == ST_SPLIT) begin
      if (load_s) begin
        valid_next_s = !full_next_s;
      end else begin
        valid_next_s = m_ar_valid_r || !full_next_s;
      end
    end else begin
      valid_next_s = 1'b0;
    end
  end

  // Registered AR payload plus split bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_ar_ready_r <= 1'b0;
      m_ar_valid_r <= 1'b0;
      m_ar_addr_r  <= '0;
      m_ar_len_r   <= 8'd0;
      m_ar_size_r  <= 3'd0;
      m_ar_burst_r <= 2'd0;
      m_ar_prot_r  <= 3'd0;
      m_ar_cache_r <= 4'd0;
      m_ar_qos_r   <= 4'd0;
      cur_beats_r  <= 9'd0;
      remaining_r  <= 9'd0;
    end else begin
      s_ar_ready_r <= (state_next_s == ST_IDLE);
      m_ar_valid_r <= valid_next_s;
      if (load_s) begin
        m_ar_addr_r  <= src_addr_s;
        m_ar_len_r   <= len_s[7:0];
        m_ar_size_r  <= src_size_s;
        m_ar_burst_r <= src_burst_s;
        cur_beats_r  <= beats_s;
        remaining_r  <= src_rem_s;
      end
      if (ar_hs_s) begin
        m_ar_prot_r  <= s_ar_prot;
        m_ar_cache_r <= s_ar_cache;
        m_ar_qos_r   <= s_ar_qos;
      end
    end
  end

  // Tag FIFO: one "final sub-burst" flag per issued AR, consumed on each downstream rlast.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= final_s;
        wr_ptr_r            <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  assign s_ar_ready = s_ar_ready_r;
  assign m_ar_valid = m_ar_valid_r;
  assign m_ar_addr  = m_ar_addr_r;
  assign m_ar_len   = m_ar_len_r;
  assign m_ar_size  = m_ar_size_r;
  assign m_ar_burst = m_ar_burst_r;
  assign m_ar_prot  = m_ar_prot_r;
  assign m_ar_cache = m_ar_cache_r;
  assign m_ar_qos   = m_ar_qos_r;

  // R channel is a straight wire except for rlast, which only survives on the final sub-burst.
  assign s_r_valid = m_r_valid;
  assign m_r_ready = s_r_ready;
  assign s_r_data  = m_r_data;
  assign s_r_resp  = m_r_resp;
  assign s_r_last  = m_r_last && !fifo_empty_s && tag_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_dbchecker_rx_burst_splitter.sv
// Directed bench for dbchecker_rx_burst_splitter: AR splitting, tag FIFO back-pressure and rlast rebuild.
module tb_dbchecker_rx_burst_splitter;

  logic          clock = 1'b0;
  logic          reset;
  logic          s_ar_valid;
  logic          s_ar_ready;
  logic [63:0]   s_ar_addr;
  logic [7:0]    s_ar_len;
  logic [2:0]    s_ar_size;
  logic [1:0]    s_ar_burst;
  logic [2:0]    s_ar_prot;
  logic [3:0]    s_ar_cache;
  logic [3:0]    s_ar_qos;
  logic          m_ar_valid;
  logic          m_ar_ready;
  logic [63:0]   m_ar_addr;
  logic [7:0]    m_ar_len;
  logic [2:0]    m_ar_size;
  logic [1:0]    m_ar_burst;
  logic [2:0]    m_ar_prot;
  logic [3:0]    m_ar_cache;
  logic [3:0]    m_ar_qos;
  logic          m_r_valid;
  logic          m_r_ready;
  logic [127:0]  m_r_data;
  logic [1:0]    m_r_resp;
  logic          m_r_last;
  logic          s_r_valid;
  logic          s_r_ready;
  logic [127:0]  s_r_data;
  logic [1:0]    s_r_resp;
  logic          s_r_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] ar_addr_q [$];
  logic [7:0]  ar_len_q [$];
  logic [1:0]  ar_burst_q [$];
  logic [2:0]  ar_size_q [$];
  int          ar_cyc_q [$];

  dbchecker_rx_burst_splitter dut (
    .clock(clock), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_ar_prot(s_ar_prot), .s_ar_cache(s_ar_cache), .s_ar_qos(s_ar_qos),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_ar_prot(m_ar_prot), .m_ar_cache(m_ar_cache), .m_ar_qos(m_ar_qos),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic issue_ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input logic [1:0] b, output bit ok);
    @(negedge clock);
    s_ar_addr  = a;
    s_ar_len   = l;
    s_ar_size  = sz;
    s_ar_burst = b;
    s_ar_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_ar_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    s_ar_valid = 1'b0;
  endtask

  task automatic collect_ars(input int cycles);
    ar_addr_q.delete();
    ar_len_q.delete();
    ar_burst_q.delete();
    ar_size_q.delete();
    ar_cyc_q.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (m_ar_valid && m_ar_ready) begin
        ar_addr_q.push_back(m_ar_addr);
        ar_len_q.push_back(m_ar_len);
        ar_burst_q.push_back(m_ar_burst);
        ar_size_q.push_back(m_ar_size);
        ar_cyc_q.push_back(cyc);
      end
    end
  endtask

  task automatic send_r(input int beats, output int nlast, output int last_idx);
    nlast    = 0;
    last_idx = -1;
    for (int b = 0; b < beats; b++) begin
      @(negedge clock);
      m_r_valid = 1'b1;
      m_r_last  = (b == beats - 1);
      m_r_data  = 128'(b);
      m_r_resp  = 2'b00;
      s_r_ready = 1'b1;
      #1;
      if (s_r_valid && s_r_last) begin
        nlast++;
        last_idx = b;
      end
    end
    @(negedge clock);
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (s_ar_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ar_ready got=%0h exp=0", s_ar_ready); end
    checks++; if (m_ar_valid !== 1'b0) begin failures++; $display("FAIL reset_m_ar_valid got=%0h exp=0", m_ar_valid); end
    checks++; if (m_ar_addr !== 64'h0 || m_ar_len !== 8'h0) begin failures++; $display("FAIL reset_payload addr=%0h len=%0h exp=0/0", m_ar_addr, m_ar_len); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (s_ar_ready !== 1'b1) begin failures++; $display("FAIL release_s_ar_ready got=%0h exp=1", s_ar_ready); end
  endtask

  task automatic test_4k_cross();
    bit ok;
    int n, li;
    issue_ar(64'h0FF0, 8'd7, 3'd4, 2'b01, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cross_ar_accept got=%0d exp=1", ok); end
    collect_ars(8);
    checks++; if (ar_addr_q.size() != 2) begin failures++; $display("FAIL cross_ar_count got=%0d exp=2", ar_addr_q.size()); end
    if (ar_addr_q.size() == 2) begin
      checks++; if (ar_addr_q[0] !== 64'h0FF0 || ar_len_q[0] !== 8'd0) begin failures++; $display("FAIL cross_ar0 addr=%0h len=%0d exp=ff0/0", ar_addr_q[0], ar_len_q[0]); end
      checks++; if (ar_addr_q[1] !== 64'h1000 || ar_len_q[1] !== 8'd6) begin failures++; $display("FAIL cross_ar1 addr=%0h len=%0d exp=1000/6", ar_addr_q[1], ar_len_q[1]); end
    end
    send_r(1, n, li);
    checks++; if (n != 0) begin failures++; $display("FAIL cross_r0_last got=%0d exp=0", n); end
    send_r(7, n, li);
    checks++; if (n != 1 || li != 6) begin failures++; $display("FAIL cross_r1_last count=%0d idx=%0d exp=1/6", n, li); end
  endtask

  task automatic test_unaligned();
    bit ok;
    int n, li;
    issue_ar(64'h0FF8, 8'd1, 3'd4, 2'b01, ok);
    collect_ars(8);
    checks++; if (ar_addr_q.size() != 2) begin failures++; $display("FAIL unal_ar_count got=%0d exp=2", ar_addr_q.size()); end
    if (ar_addr_q.size() == 2) begin
      checks++; if (ar_addr_q[0] !== 64'h0FF8 || ar_len_q[0] !== 8'd0) begin failures++; $display("FAIL unal_ar0 addr=%0h len=%0d exp=ff8/0", ar_addr_q[0], ar_len_q[0]); end
      checks++; if (ar_addr_q[1] !== 64'h1000 || ar_len_q[1] !== 8'd0) begin failures++; $display("FAIL unal_ar1 addr=%0h len=%0d exp=1000/0", ar_addr_q[1], ar_len_q[1]); end
    end
    send_r(1, n, li);
    checks++; if (n != 0) begin failures++; $display("FAIL unal_r0_last got=%0d exp=0", n); end
    send_r(1, n, li);
    checks++; if (n != 1) begin failures++; $display("FAIL unal_r1_last got=%0d exp=1", n); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n, li;
    logic [63:0] exp_addr;
    issue_ar(64'h2000, 8'd63, 3'd4, 2'b01, ok);
    collect_ars(10);
    checks++; if (ar_addr_q.size() != 4) begin failures++; $display("FAIL b2b_ar_count got=%0d exp=4", ar_addr_q.size()); end
    if (ar_addr_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_addr = 64'h2000 + 64'(k) * 64'h100;
        checks++; if (ar_addr_q[k] !== exp_addr || ar_len_q[k] !== 8'd15 || ar_size_q[k] !== 3'd4) begin
          failures++; $display("FAIL b2b_ar%0d addr=%0h len=%0d size=%0d exp=%0h/15/4", k, ar_addr_q[k], ar_len_q[k], ar_size_q[k], exp_addr); end
      end
      checks++; if (ar_cyc_q[3] - ar_cyc_q[0] != 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", ar_cyc_q[3] - ar_cyc_q[0]); end
    end
    for (int k = 0; k < 4; k++) begin
      send_r(16, n, li);
      checks++; if (n != ((k == 3) ? 1 : 0)) begin failures++; $display("FAIL b2b_r%0d_last got=%0d exp=%0d", k, n, (k == 3) ? 1 : 0); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int n, li;
    issue_ar(64'h0FF0, 8'd3, 3'd4, 2'b10, ok);
    collect_ars(6);
    checks++; if (ar_addr_q.size() != 1) begin failures++; $display("FAIL wrap_ar_count got=%0d exp=1", ar_addr_q.size()); end
    if (ar_addr_q.size() == 1) begin
      checks++; if (ar_addr_q[0] !== 64'h0FF0 || ar_len_q[0] !== 8'd3 || ar_burst_q[0] !== 2'b10 || ar_size_q[0] !== 3'd4) begin
        failures++; $display("FAIL wrap_ar addr=%0h len=%0d burst=%0d size=%0d exp=ff0/3/2/4", ar_addr_q[0], ar_len_q[0], ar_burst_q[0], ar_size_q[0]); end
    end
    send_r(4, n, li);
    checks++; if (n != 1 || li != 3) begin failures++; $display("FAIL wrap_r_last count=%0d idx=%0d exp=1/3", n, li); end
  endtask

  task automatic test_rpath();
    @(negedge clock);
    m_r_valid = 1'b1;
    m_r_data  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    m_r_resp  = 2'b10;
    m_r_last  = 1'b0;
    s_r_ready = 1'b1;
    #1;
    checks++; if (s_r_valid !== 1'b1 || m_r_ready !== 1'b1) begin failures++; $display("FAIL rpath_hs s_r_valid=%0h m_r_ready=%0h exp=1/1", s_r_valid, m_r_ready); end
    checks++; if (s_r_data !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 || s_r_resp !== 2'b10) begin
      failures++; $display("FAIL rpath_data data=%0h resp=%0h exp=0123456789abcdeffedcba9876543210/2", s_r_data, s_r_resp); end
    s_r_ready = 1'b0;
    #1;
    checks++; if (m_r_ready !== 1'b0) begin failures++; $display("FAIL rpath_ready got=%0h exp=0", m_r_ready); end
    @(negedge clock);
    m_r_valid = 1'b0;
    s_r_ready = 1'b1;
  endtask

  task automatic test_fifo_full();
    bit ok;
    int n, li;
    issue_ar(64'h2000, 8'd255, 3'd4, 2'b01, ok);
    collect_ars(12);
    checks++; if (ar_addr_q.size() != 4) begin failures++; $display("FAIL full_ar_count got=%0d exp=4", ar_addr_q.size()); end
    checks++; if (m_ar_valid !== 1'b0) begin failures++; $display("FAIL full_stall got=%0h exp=0", m_ar_valid); end
    send_r(16, n, li);
    checks++; if (n != 0) begin failures++; $display("FAIL full_r_last got=%0d exp=0", n); end
    checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 64'h2400 || m_ar_len !== 8'd15) begin
      failures++; $display("FAIL full_release valid=%0h addr=%0h len=%0d exp=1/2400/15", m_ar_valid, m_ar_addr, m_ar_len); end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n, li;
    m_ar_ready = 1'b0;
    issue_ar(64'h2000, 8'd63, 3'd4, 2'b01, ok);
    m_ar_ready = 1'b1;
    @(posedge clock);
    #1;
    m_ar_ready = 1'b0;
    @(negedge clock);
    checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 64'h2100) begin failures++; $display("FAIL mid_second valid=%0h addr=%0h exp=1/2100", m_ar_valid, m_ar_addr); end
    reset = 1'b0;
    #1;
    checks++; if (m_ar_valid !== 1'b0 || s_ar_ready !== 1'b0) begin failures++; $display("FAIL mid_reset valid=%0h ready=%0h exp=0/0", m_ar_valid, s_ar_ready); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (s_ar_ready !== 1'b1 || m_ar_valid !== 1'b0) begin failures++; $display("FAIL mid_release ready=%0h valid=%0h exp=1/0", s_ar_ready, m_ar_valid); end
    m_ar_ready = 1'b1;
    issue_ar(64'h0FF0, 8'd7, 3'd4, 2'b01, ok);
    collect_ars(8);
    checks++; if (ar_addr_q.size() != 2) begin failures++; $display("FAIL mid_ar_count got=%0d exp=2", ar_addr_q.size()); end
    if (ar_addr_q.size() == 2) begin
      checks++; if (ar_addr_q[1] !== 64'h1000 || ar_len_q[1] !== 8'd6) begin failures++; $display("FAIL mid_ar1 addr=%0h len=%0d exp=1000/6", ar_addr_q[1], ar_len_q[1]); end
    end
    send_r(1, n, li);
    checks++; if (n != 0) begin failures++; $display("FAIL mid_r0_last got=%0d exp=0", n); end
    send_r(7, n, li);
    checks++; if (n != 1 || li != 6) begin failures++; $display("FAIL mid_r1_last count=%0d idx=%0d exp=1/6", n, li); end
  endtask

  initial begin
    reset      = 1'b0;
    s_ar_valid = 1'b0;
    s_ar_addr  = 64'h0;
    s_ar_len   = 8'd0;
    s_ar_size  = 3'd0;
    s_ar_burst = 2'b01;
    s_ar_prot  = 3'd2;
    s_ar_cache = 4'd3;
    s_ar_qos   = 4'd1;
    m_ar_ready = 1'b1;
    m_r_valid  = 1'b0;
    m_r_data   = 128'h0;
    m_r_resp   = 2'b00;
    m_r_last   = 1'b0;
    s_r_ready  = 1'b1;
    test_reset();
    test_4k_cross();
    test_unaligned();
    test_back_to_back();
    test_wrap();
    test_rpath();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
